// File: rtl/cpu86_exec_register_tracer.sv
// Shadow AX..DI/FL register file that emits a full register snapshot for every retired instruction.
// Macro CPU86_TRACE_FIFO_EN selects a DEPTH-entry valid/ready queue; otherwise a single output register.
module cpu86_exec_register_tracer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr0_valid,
  input  logic [3:0]  wr0_idx,
  input  logic [1:0]  wr0_mask,
  input  logic [15:0] wr0_data,
  input  logic        wr1_valid,
  input  logic [3:0]  wr1_idx,
  input  logic [1:0]  wr1_mask,
  input  logic [15:0] wr1_data,
  input  logic        ret_valid,
  input  logic [4:0]  ret_op,
  input  logic [3:0]  ret_code,
  input  logic [15:0] ret_cs,
  input  logic [15:0] ret_ip,
  output logic        vld_valid,
  input  logic        vld_ready,
  output logic [4:0]  vld_op,
  output logic [3:0]  vld_code,
  output logic [15:0] vld_cs,
  output logic [15:0] vld_ip,
  output logic [15:0] vld_ax,
  output logic [15:0] vld_bx,
  output logic [15:0] vld_cx,
  output logic [15:0] vld_dx,
  output logic [15:0] vld_bp,
  output logic [15:0] vld_sp,
  output logic [15:0] vld_si,
  output logic [15:0] vld_di,
  output logic [15:0] vld_fl,
  output logic        trace_ovf
);

  localparam int unsigned NREG   = 9;
  localparam int unsigned SNAP_W = 5 + 4 + 16 * 2 + 16 * NREG;
  localparam logic [15:0] FL_RST = 16'h0002;

  logic [NREG-1:0][15:0] regs_d;
  logic [SNAP_W-1:0]     snap_d;
  logic [SNAP_W-1:0]     head;

  // Per-register byte-lane update; wr1 is applied last so it wins a shared lane.
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    localparam logic [15:0] RST_VAL = (g == NREG - 1) ? FL_RST : 16'h0000;
    logic [15:0] reg_q;
    logic [15:0] reg_d;

    always_comb begin
      reg_d = reg_q;
      if (wr0_valid && wr0_idx == 4'(g)) begin
        if (wr0_mask[0]) reg_d[7:0]  = wr0_data[7:0];
        if (wr0_mask[1]) reg_d[15:8] = wr0_data[15:8];
      end
      if (wr1_valid && wr1_idx == 4'(g)) begin
        if (wr1_mask[0]) reg_d[7:0]  = wr1_data[7:0];
        if (wr1_mask[1]) reg_d[15:8] = wr1_data[15:8];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) reg_q <= RST_VAL;
      else       reg_q <= reg_d;
    end

    assign regs_d[g] = reg_d;
  end

  // Snapshot sees same-cycle writes through the bypassed next-state values.
  assign snap_d = {ret_op, ret_code, ret_cs, ret_ip, regs_d};

  assign {vld_op, vld_code, vld_cs, vld_ip,
          vld_fl, vld_di, vld_si, vld_sp, vld_bp, vld_dx, vld_cx, vld_bx, vld_ax} = head;

`ifdef CPU86_TRACE_FIFO_EN
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [SNAP_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_q;
  logic [PW-1:0]     wr_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              valid_q;
  logic              ovf_q;
  logic              push_c;
  logic              pop_c;

  always_comb begin
    pop_c  = valid_q && vld_ready;
    push_c = ret_valid && ((cnt_q < CW'(DEPTH)) || pop_c);
    cnt_d  = cnt_q + CW'(push_c) - CW'(pop_c);
  end

  // A push at full without a pop is dropped and flagged; the queue itself is untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[wr_q] <= snap_d;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_c) rd_q <= rd_q + PW'(1);
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      if (ret_valid && !push_c) ovf_q <= 1'b1;
    end
  end

  assign head      = mem_q[rd_q];
  assign vld_valid = valid_q;
  assign trace_ovf = ovf_q;
`else
  logic [SNAP_W-1:0] snap_q;
  logic              valid_q;
  logic              unused_ok;

  // Checker has no ready input: every retire reloads the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= ret_valid;
      if (ret_valid) snap_q <= snap_d;
    end
  end

  assign head      = snap_q;
  assign vld_valid = valid_q;
  assign trace_ovf = 1'b0;
  assign unused_ok = vld_ready ^ (DEPTH == 0);
`endif

endmodule

// File: tb/tb_cpu86_exec_register_tracer.sv
// Randomized and directed bench for cpu86_exec_register_tracer against a queue-based reference model.
// Honours CPU86_TRACE_FIFO_EN the same way as the design.
module tb_cpu86_exec_register_tracer;

  localparam int unsigned DEPTH = 4;
`ifdef CPU86_TRACE_FIFO_EN
  localparam bit FIFO_MODE = 1'b1;
`else
  localparam bit FIFO_MODE = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]       op;
    logic [3:0]       code;
    logic [15:0]      cs;
    logic [15:0]      ip;
    logic [8:0][15:0] r;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr0_valid, wr1_valid;
  logic [3:0]  wr0_idx, wr1_idx;
  logic [1:0]  wr0_mask, wr1_mask;
  logic [15:0] wr0_data, wr1_data;
  logic        ret_valid;
  logic [4:0]  ret_op;
  logic [3:0]  ret_code;
  logic [15:0] ret_cs, ret_ip;
  logic        vld_valid, vld_ready;
  logic [4:0]  vld_op;
  logic [3:0]  vld_code;
  logic [15:0] vld_cs, vld_ip;
  logic [15:0] vld_ax, vld_bx, vld_cx, vld_dx, vld_bp, vld_sp, vld_si, vld_di, vld_fl;
  logic        trace_ovf;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_reg [9];
  snap_t       q[$];
  snap_t       exp_snap;
  logic        exp_valid;
  logic        exp_ovf;

  always #5 clk = ~clk;

  cpu86_exec_register_tracer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr0_valid(wr0_valid), .wr0_idx(wr0_idx), .wr0_mask(wr0_mask), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_idx(wr1_idx), .wr1_mask(wr1_mask), .wr1_data(wr1_data),
    .ret_valid(ret_valid), .ret_op(ret_op), .ret_code(ret_code), .ret_cs(ret_cs), .ret_ip(ret_ip),
    .vld_valid(vld_valid), .vld_ready(vld_ready),
    .vld_op(vld_op), .vld_code(vld_code), .vld_cs(vld_cs), .vld_ip(vld_ip),
    .vld_ax(vld_ax), .vld_bx(vld_bx), .vld_cx(vld_cx), .vld_dx(vld_dx),
    .vld_bp(vld_bp), .vld_sp(vld_sp), .vld_si(vld_si), .vld_di(vld_di), .vld_fl(vld_fl),
    .trace_ovf(trace_ovf)
  );

  function automatic snap_t obs();
    snap_t s;
    s.op = vld_op; s.code = vld_code; s.cs = vld_cs; s.ip = vld_ip;
    s.r[0] = vld_ax; s.r[1] = vld_bx; s.r[2] = vld_cx; s.r[3] = vld_dx;
    s.r[4] = vld_bp; s.r[5] = vld_sp; s.r[6] = vld_si; s.r[7] = vld_di; s.r[8] = vld_fl;
    return s;
  endfunction

  task automatic apply_write(input logic v, input logic [3:0] idx, input logic [1:0] m,
                             input logic [15:0] d);
    int unsigned i;
    i = int'(idx);
    if (v && i < 9) begin
      if (m[0]) m_reg[i][7:0]  = d[7:0];
      if (m[1]) m_reg[i][15:8] = d[15:8];
    end
  endtask

  // Advance the model by one clock using the inputs currently driven, then step the DUT.
  task automatic tick();
    snap_t s;
    logic  pop;
    if (reset) begin
      for (int k = 0; k < 9; k++) m_reg[k] = (k == 8) ? 16'h0002 : 16'h0000;
      q.delete();
      exp_valid = 1'b0;
      exp_snap  = '0;
      exp_ovf   = 1'b0;
    end else begin
      apply_write(wr0_valid, wr0_idx, wr0_mask, wr0_data);
      apply_write(wr1_valid, wr1_idx, wr1_mask, wr1_data);
      s.op = ret_op; s.code = ret_code; s.cs = ret_cs; s.ip = ret_ip;
      for (int k = 0; k < 9; k++) s.r[k] = m_reg[k];
      if (FIFO_MODE) begin
        pop = (q.size() > 0) && vld_ready;
        if (pop) void'(q.pop_front());
        if (ret_valid) begin
          if (q.size() < DEPTH) q.push_back(s);
          else exp_ovf = 1'b1;
        end
        exp_valid = (q.size() > 0);
        if (exp_valid) exp_snap = q[0];
      end else begin
        exp_valid = ret_valid;
        if (ret_valid) exp_snap = s;
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0; wr0_valid = 1'b0; wr1_valid = 1'b0; ret_valid = 1'b0;
  endtask

  task automatic set_ret(input logic [4:0] op, input logic [3:0] code,
                         input logic [15:0] cs, input logic [15:0] ip);
    ret_valid = 1'b1; ret_op = op; ret_code = code; ret_cs = cs; ret_ip = ip;
  endtask

  task automatic set_wr0(input logic [3:0] idx, input logic [1:0] m, input logic [15:0] d);
    wr0_valid = 1'b1; wr0_idx = idx; wr0_mask = m; wr0_data = d;
  endtask

  task automatic set_wr1(input logic [3:0] idx, input logic [1:0] m, input logic [15:0] d);
    wr1_valid = 1'b1; wr1_idx = idx; wr1_mask = m; wr1_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick();
    reset = 1'b1; tick();
    total++; if (vld_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", vld_valid); end
    total++; if (obs() !== snap_t'(0)) begin bad++; $display("FAIL reset_data: got %h want 0", obs()); end
    total++; if (trace_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", trace_ovf); end
  endtask

  task automatic test_first_retire();
    vld_ready = 1'b1;
    set_ret(5'd0, 4'd0, 16'hF000, 16'hFFF0);
    tick();
    total++; if (vld_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", vld_valid); end
    total++; if (obs() !== exp_snap) begin bad++; $display("FAIL first_snap: got %h want %h", obs(), exp_snap); end
    total++; if (vld_fl !== 16'h0002 || vld_ax !== 16'h0000 || vld_di !== 16'h0000)
      begin bad++; $display("FAIL first_regs: got fl=%h ax=%h di=%h want 0002/0000/0000", vld_fl, vld_ax, vld_di); end
    total++; if ({vld_cs, vld_ip} !== 32'hF000FFF0)
      begin bad++; $display("FAIL first_csip: got %h:%h want F000:FFF0", vld_cs, vld_ip); end
    tick();
    total++; if (vld_valid !== 1'b0) begin bad++; $display("FAIL first_idle: got %b want 0", vld_valid); end
  endtask

  task automatic test_bypass();
    vld_ready = 1'b1;
    set_wr0(4'd0, 2'b11, 16'h1234);
    set_ret(5'd0, 4'd1, 16'h0100, 16'h0010);
    tick();
    total++; if (vld_valid !== 1'b1 || vld_ax !== 16'h1234)
      begin bad++; $display("FAIL bypass_ax: got v=%b ax=%h want 1/1234", vld_valid, vld_ax); end
  endtask

  task automatic test_lanes();
    vld_ready = 1'b1;
    set_wr0(4'd0, 2'b10, 16'hAB00);
    set_ret(5'd0, 4'd2, 16'h0100, 16'h0012);
    tick();
    total++; if (vld_ax !== 16'hAB34) begin bad++; $display("FAIL lane_hi: got %h want AB34", vld_ax); end
    set_wr0(4'd0, 2'b11, 16'h0005);
    set_wr1(4'd1, 2'b11, 16'h0007);
    set_ret(5'd5, 4'd0, 16'h0100, 16'h0014);
    tick();
    total++; if (vld_ax !== 16'h0005 || vld_bx !== 16'h0007)
      begin bad++; $display("FAIL xchg: got ax=%h bx=%h want 0005/0007", vld_ax, vld_bx); end
    set_wr0(4'd2, 2'b11, 16'h0001);
    set_wr1(4'd2, 2'b11, 16'h0002);
    set_ret(5'd0, 4'd0, 16'h0100, 16'h0016);
    tick();
    total++; if (vld_cx !== 16'h0002) begin bad++; $display("FAIL wr1_wins: got %h want 0002", vld_cx); end
    set_wr0(4'd9, 2'b11, 16'hFFFF);
    set_wr1(4'd3, 2'b00, 16'hFFFF);
    set_ret(5'd0, 4'd0, 16'h0100, 16'h0018);
    tick();
    total++; if (vld_dx !== 16'h0000 || vld_fl !== 16'h0002 || obs() !== exp_snap)
      begin bad++; $display("FAIL ignored_writes: got %h want %h", obs(), exp_snap); end
  endtask

  task automatic test_back_to_back();
    vld_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_ret(5'(i), 4'(i), 16'h2000, 16'h0100 + 16'(i));
      tick();
      total++; if (vld_valid !== 1'b1 || vld_ip !== 16'h0100 + 16'(i))
        begin bad++; $display("FAIL b2b_%0d: got v=%b ip=%h want 1/%h", i, vld_valid, vld_ip, 16'h0100 + 16'(i)); end
    end
    tick();
    total++; if (vld_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b want 0", vld_valid); end
  endtask

  task automatic test_overflow();
    vld_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ret(5'd1, 4'd0, 16'h3000, 16'h0200 + 16'(i));
      tick();
      total++; if (vld_valid !== 1'b1 || obs() !== exp_snap)
        begin bad++; $display("FAIL ovf_fill_%0d: got %h want %h", i, obs(), exp_snap); end
    end
    total++; if (trace_ovf !== exp_ovf) begin bad++; $display("FAIL ovf_flag: got %b want %b", trace_ovf, exp_ovf); end
`ifdef CPU86_TRACE_FIFO_EN
    total++; if (trace_ovf !== 1'b1 || vld_ip !== 16'h0200)
      begin bad++; $display("FAIL ovf_head: got ovf=%b ip=%h want 1/0200", trace_ovf, vld_ip); end
    vld_ready = 1'b1;
    set_ret(5'd1, 4'd0, 16'h3000, 16'h02FF);
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [15:0] want_ip;
      want_ip = (i == 3) ? 16'h02FF : 16'h0201 + 16'(i);
      total++; if (vld_valid !== 1'b1 || vld_ip !== want_ip)
        begin bad++; $display("FAIL drain_%0d: got v=%b ip=%h want 1/%h", i, vld_valid, vld_ip, want_ip); end
      tick();
    end
    total++; if (vld_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", vld_valid); end
`else
    total++; if (trace_ovf !== 1'b0 || vld_ip !== 16'h0204)
      begin bad++; $display("FAIL noq_last: got ovf=%b ip=%h want 0/0204", trace_ovf, vld_ip); end
    tick();
`endif
  endtask

  task automatic test_backpressure();
    logic [15:0] sent[$];
    logic [15:0] seen[$];
    snap_t       prev;
    logic        hold;
    hold = 1'b0;
    prev = '0;
    for (int c = 0; c < 14; c++) begin
      vld_ready = c[0];
      if (c < 4) begin
        set_ret(5'd3, 4'd1, 16'h1000, 16'h0300 + 16'(c));
        sent.push_back(ret_ip);
      end
      if (vld_valid && (!FIFO_MODE || vld_ready)) seen.push_back(vld_ip);
      hold = FIFO_MODE && vld_valid && !vld_ready;
      prev = obs();
      tick();
      total++; if (vld_valid !== exp_valid)
        begin bad++; $display("FAIL bp_valid_%0d: got %b want %b", c, vld_valid, exp_valid); end
      if (hold) begin
        total++; if (vld_valid !== 1'b1 || obs() !== prev)
          begin bad++; $display("FAIL bp_hold_%0d: got %h want %h", c, obs(), prev); end
      end
    end
    total++; if (seen.size() !== sent.size())
      begin bad++; $display("FAIL bp_count: got %0d want %0d", seen.size(), sent.size()); end
    for (int i = 0; i < sent.size() && i < seen.size(); i++) begin
      total++; if (seen[i] !== sent[i])
        begin bad++; $display("FAIL bp_order_%0d: got %h want %h", i, seen[i], sent[i]); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1) set_wr0(4'($urandom_range(0, 15)), 2'($urandom), 16'($urandom));
      if ($urandom_range(0, 2) == 0) set_wr1(4'($urandom_range(0, 15)), 2'($urandom), 16'($urandom));
      if ($urandom_range(0, 1) == 1) set_ret(5'($urandom_range(0, 23)), 4'($urandom), 16'($urandom), 16'($urandom));
      vld_ready = ($urandom_range(0, 3) != 0);
      tick();
      total++; if (vld_valid !== exp_valid)
        begin bad++; $display("FAIL rnd_valid_%0d: got %b want %b", c, vld_valid, exp_valid); end
      if (exp_valid) begin
        total++; if (obs() !== exp_snap)
          begin bad++; $display("FAIL rnd_snap_%0d: got %h want %h", c, obs(), exp_snap); end
      end
      total++; if (trace_ovf !== exp_ovf)
        begin bad++; $display("FAIL rnd_ovf_%0d: got %b want %b", c, trace_ovf, exp_ovf); end
    end
  endtask

  task automatic test_midreset();
    vld_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ret(5'd4, 4'd2, 16'h4000, 16'h0400 + 16'(i));
      tick();
    end
    reset = 1'b1;
    tick();
    tick();
    total++; if (vld_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", vld_valid); end
    total++; if (trace_ovf !== 1'b0) begin bad++; $display("FAIL midrst_ovf: got %b want 0", trace_ovf); end
    vld_ready = 1'b1;
    set_ret(5'd0, 4'd0, 16'h4000, 16'h0500);
    tick();
    total++; if (vld_valid !== 1'b1 || vld_ip !== 16'h0500 || obs() !== exp_snap)
      begin bad++; $display("FAIL midrst_next: got %h want %h", obs(), exp_snap); end
  endtask

  initial begin
    reset = 1'b1; vld_ready = 1'b0;
    wr0_valid = 1'b0; wr0_idx = '0; wr0_mask = '0; wr0_data = '0;
    wr1_valid = 1'b0; wr1_idx = '0; wr1_mask = '0; wr1_data = '0;
    ret_valid = 1'b0; ret_op = '0; ret_code = '0; ret_cs = '0; ret_ip = '0;
    exp_valid = 1'b0; exp_snap = '0; exp_ovf = 1'b0;
    test_reset();
    test_first_retire();
    test_bypass();
    test_lanes();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
